matrix_pixel_fetch: RTL and testbench

- Sits directly downstream of the matrix scan stage and upstream of the panel data pins.
- Converts the scan stage's column/row/brightness-bit position into framebuffer reads: one read returns the top-half pixel and the bottom-half pixel. It then reduces each RGB colour channel to one bit using the current brightness mask.
- Owns the double-buffered framebuffer bank select, with a swap handshake to the framebuffer writer that is honoured only at a frame boundary.

---
 rtl/matrix_pixel_fetch_pkg.sv | 24 ++
 rtl/matrix_pixel_fetch_bitplane_select.sv | 15 +
 rtl/matrix_pixel_fetch.sv | 109 ++++++++++
 tb/tb_matrix_pixel_fetch.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pixel_fetch_pkg.sv
// Shared constants, ram_data channel layout and swap FSM encoding for the
// matrix pixel fetch stage.
package matrix_pixel_fetch_pkg;

    localparam int COLOR_DEPTH = 6;
    localparam int ROW_BITS    = 4;
    localparam int COL_BITS    = 6;
    localparam int STAGES      = 2;

    // Channel slot within ram_data, in units of COLOR_DEPTH (top R is MSB).
    localparam int TOP_R = 5;
    localparam int TOP_G = 4;
    localparam int TOP_B = 3;
    localparam int BOT_R = 2;
    localparam int BOT_G = 1;
    localparam int BOT_B = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ACKED = 2'd2
    } swap_state_e;

endpackage

// File: rtl/matrix_pixel_fetch_bitplane_select.sv
// Reduces one RGB triple to a single bit per channel for the selected
// brightness plane(s).
module bitplane_select #(
    parameter int COLOR_DEPTH = matrix_pixel_fetch_pkg::COLOR_DEPTH
) (
    input  logic [2:0][COLOR_DEPTH-1:0] chan,
    input  logic [COLOR_DEPTH-1:0]      mask,
    output logic [2:0]                  rgb
);

    for (genvar c = 0; c < 3; c++) begin : g_chan
        assign rgb[c] = |(chan[c] & mask);
    end

endmodule

// File: rtl/matrix_pixel_fetch.sv
// Framebuffer read pipeline feeding the panel pins, plus the double-buffer
// bank select with a frame-boundary swap handshake.
module matrix_pixel_fetch #(
    parameter int COLOR_DEPTH = matrix_pixel_fetch_pkg::COLOR_DEPTH,
    parameter int ROW_BITS    = matrix_pixel_fetch_pkg::ROW_BITS,
    parameter int COL_BITS    = matrix_pixel_fetch_pkg::COL_BITS
) (
    input  logic                         clk_in,
    input  logic                         reset,
    input  logic                         pixel_load_en,
    input  logic [COL_BITS-1:0]          column_address,
    input  logic [ROW_BITS-1:0]          row_address,
    input  logic [COLOR_DEPTH-1:0]       brightness_mask,
    output logic [ROW_BITS+COL_BITS:0]   ram_addr,
    output logic                         ram_rd_en,
    input  logic [6*COLOR_DEPTH-1:0]     ram_data,
    output logic [2:0]                   rgb_top,
    output logic [2:0]                   rgb_bottom,
    output logic                         pixel_valid,
    input  logic                         swap_req,
    output logic                         swap_ack,
    output logic                         display_bank,
    output logic                         write_bank
);
    import matrix_pixel_fetch_pkg::*;

    logic [STAGES:1]                    vld_pipe;
    logic [COLOR_DEPTH-1:0]             mask_s1, mask_s2;
    logic [1:0][2:0][COLOR_DEPTH-1:0]   chan;
    logic [1:0][2:0]                    rgb_sel;
    swap_state_e                        swap_state;
    logic                               frame_boundary, swap_fire, bank_next;

    assign frame_boundary = (row_address == '0) && (&column_address)
                         && (brightness_mask == COLOR_DEPTH'(1));
    assign swap_fire      = (swap_state == ARMED) && swap_req
                         && pixel_load_en && frame_boundary;
    // The boundary strobe that triggers the swap already reads the new bank.
    assign bank_next      = display_bank ^ swap_fire;
    assign write_bank     = ~display_bank;

    assign chan[1] = {ram_data[TOP_R*COLOR_DEPTH +: COLOR_DEPTH],
                      ram_data[TOP_G*COLOR_DEPTH +: COLOR_DEPTH],
                      ram_data[TOP_B*COLOR_DEPTH +: COLOR_DEPTH]};
    assign chan[0] = {ram_data[BOT_R*COLOR_DEPTH +: COLOR_DEPTH],
                      ram_data[BOT_G*COLOR_DEPTH +: COLOR_DEPTH],
                      ram_data[BOT_B*COLOR_DEPTH +: COLOR_DEPTH]};

    for (genvar h = 0; h < 2; h++) begin : g_half
        bitplane_select #(.COLOR_DEPTH(COLOR_DEPTH)) u_bp (
            .chan (chan[h]),
            .mask (mask_s2),
            .rgb  (rgb_sel[h])
        );
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            ram_addr    <= '0;
            ram_rd_en   <= 1'b0;
            mask_s1     <= '0;
            mask_s2     <= '0;
            vld_pipe    <= '0;
            rgb_top     <= '0;
            rgb_bottom  <= '0;
            pixel_valid <= 1'b0;
        end else begin
            ram_rd_en <= pixel_load_en;
            if (pixel_load_en) begin
                ram_addr <= {bank_next, row_address, column_address};
                mask_s1  <= brightness_mask;
            end
            mask_s2     <= mask_s1;
            vld_pipe    <= {vld_pipe[STAGES-1:1], pixel_load_en};
            pixel_valid <= vld_pipe[STAGES];
            if (vld_pipe[STAGES]) begin
                rgb_top    <= rgb_sel[1];
                rgb_bottom <= rgb_sel[0];
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            swap_state   <= IDLE;
            swap_ack     <= 1'b0;
            display_bank <= 1'b0;
        end else begin
            swap_ack <= 1'b0;
            case (swap_state)
                IDLE:  if (swap_req) swap_state <= ARMED;
                ARMED: begin
                    if (!swap_req) begin
                        swap_state <= IDLE;
                    end else if (swap_fire) begin
                        swap_state   <= ACKED;
                        display_bank <= ~display_bank;
                        swap_ack     <= 1'b1;
                    end
                end
                // Stay here until the writer drops its request, so one request
                // never yields two swaps.
                ACKED: if (!swap_req) swap_state <= IDLE;
                default: swap_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_pixel_fetch.sv
// Directed bench for matrix_pixel_fetch with a one-cycle-latency RAM model.
module tb_matrix_pixel_fetch;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        pixel_load_en;
    logic [5:0]  column_address;
    logic [3:0]  row_address;
    logic [5:0]  brightness_mask;
    logic [10:0] ram_addr;
    logic        ram_rd_en;
    logic [35:0] ram_data;
    logic [2:0]  rgb_top, rgb_bottom;
    logic        pixel_valid;
    logic        swap_req, swap_ack, display_bank, write_bank;

    logic [17:0] pat_top, pat_bot;
    int tests = 0;
    int fails = 0;

    always #5 clk_in = ~clk_in;

    matrix_pixel_fetch dut (
        .clk_in          (clk_in),
        .reset           (reset),
        .pixel_load_en   (pixel_load_en),
        .column_address  (column_address),
        .row_address     (row_address),
        .brightness_mask (brightness_mask),
        .ram_addr        (ram_addr),
        .ram_rd_en       (ram_rd_en),
        .ram_data        (ram_data),
        .rgb_top         (rgb_top),
        .rgb_bottom      (rgb_bottom),
        .pixel_valid     (pixel_valid),
        .swap_req        (swap_req),
        .swap_ack        (swap_ack),
        .display_bank    (display_bank),
        .write_bank      (write_bank)
    );

    // Synchronous RAM: data for the registered address appears next cycle.
    always @(posedge clk_in)
        if (ram_rd_en) ram_data <= {pat_top, pat_bot};

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [3:0] r, input logic [5:0] c, input logic [5:0] m);
        pixel_load_en   = 1'b1;
        row_address     = r;
        column_address  = c;
        brightness_mask = m;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] masks   [8];
        logic [2:0] exp_top [8];
        logic [2:0] exp_bot [8];
        masks   = '{6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32, 6'd0, 6'd3};
        exp_top = '{3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 3'b010};
        exp_bot = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b101, 3'b000, 3'b100};

        // Reset held with strobes active
        reset = 1'b0; swap_req = 1'b0; pat_top = '0; pat_bot = '0;
        strobe(4'd3, 6'd12, 6'd1);
        tick; tick;
        check("rst_addr",  32'(ram_addr), 32'h0);
        check("rst_rden",  32'(ram_rd_en), 32'h0);
        check("rst_top",   32'(rgb_top), 32'h0);
        check("rst_bot",   32'(rgb_bottom), 32'h0);
        check("rst_valid", 32'(pixel_valid), 32'h0);
        check("rst_ack",   32'(swap_ack), 32'h0);
        check("rst_bank",  32'(display_bank), 32'h0);
        check("rst_wbank", 32'(write_bank), 32'h1);
        pixel_load_en = 1'b0;
        reset = 1'b1;
        tick;

        // First pixel latency
        pat_top = {6'b000100, 12'b0};
        strobe(4'd2, 6'd9, 6'd4);
        tick;
        pixel_load_en = 1'b0;
        check("lat_rden",   32'(ram_rd_en), 32'h1);
        check("lat_addr",   32'(ram_addr), 32'h089);
        check("lat_vld_n1", 32'(pixel_valid), 32'h0);
        tick;
        check("lat_rden_off", 32'(ram_rd_en), 32'h0);
        check("lat_addr_hold", 32'(ram_addr), 32'h089);
        check("lat_vld_n2", 32'(pixel_valid), 32'h0);
        tick;
        check("lat_vld", 32'(pixel_valid), 32'h1);
        check("lat_top", 32'(rgb_top), 32'h4);
        tick;
        check("lat_vld_drop", 32'(pixel_valid), 32'h0);

        // 64 back-to-back strobes, column 63 down to 0
        for (int i = 0; i < 66; i++) begin
            if (i < 64) strobe(4'd5, 6'(63 - i), 6'b000100);
            else        pixel_load_en = 1'b0;
            tick;
            if (i < 64) check("pipe_addr", 32'(ram_addr), 32'({1'b0, 4'd5, 6'(63 - i)}));
            if (i >= 2) begin
                check("pipe_vld", 32'(pixel_valid), 32'h1);
                check("pipe_top", 32'(rgb_top), 32'h4);
                check("pipe_bot", 32'(rgb_bottom), 32'h0);
            end else begin
                check("pipe_vld_fill", 32'(pixel_valid), 32'h0);
            end
        end
        tick;
        check("pipe_drain", 32'(pixel_valid), 32'h0);

        // Mask sweep, including zero and non-one-hot masks
        pat_top = {6'b0, 6'b101010, 6'b0};
        pat_bot = {6'b111111, 6'b0, 6'b100000};
        for (int i = 0; i < 10; i++) begin
            if (i < 8) strobe(4'd3, 6'd10, masks[i]);
            else       pixel_load_en = 1'b0;
            tick;
            if (i >= 2) begin
                check("mask_vld", 32'(pixel_valid), 32'h1);
                check("mask_top", 32'(rgb_top), 32'(exp_top[i-2]));
                check("mask_bot", 32'(rgb_bottom), 32'(exp_bot[i-2]));
            end
        end

        // Swap requested mid-frame; only a true boundary strobe swaps
        swap_req = 1'b1;
        strobe(4'd2, 6'd63, 6'd1); tick;
        check("sw_row_bank", 32'(display_bank), 32'h0);
        strobe(4'd0, 6'd63, 6'd2); tick;
        check("sw_mask_bank", 32'(display_bank), 32'h0);
        check("sw_mask_addr", 32'(ram_addr), 32'h03F);
        strobe(4'd0, 6'd62, 6'd1); tick;
        check("sw_col_bank", 32'(display_bank), 32'h0);
        check("sw_col_ack",  32'(swap_ack), 32'h0);
        strobe(4'd0, 6'd63, 6'd1); tick;
        check("sw_bank",  32'(display_bank), 32'h1);
        check("sw_ack",   32'(swap_ack), 32'h1);
        check("sw_addr",  32'(ram_addr), 32'h43F);
        check("sw_wbank", 32'(write_bank), 32'h0);
        pixel_load_en = 1'b0; tick;
        check("sw_ack_pulse", 32'(swap_ack), 32'h0);
        strobe(4'd0, 6'd63, 6'd1); tick;
        check("sw_hold_bank", 32'(display_bank), 32'h1);
        check("sw_hold_ack",  32'(swap_ack), 32'h0);
        check("sw_hold_addr", 32'(ram_addr), 32'h43F);
        pixel_load_en = 1'b0; swap_req = 1'b0; tick;

        // Swap cancelled before the boundary
        swap_req = 1'b1; tick;
        swap_req = 1'b0; tick;
        strobe(4'd0, 6'd63, 6'd1); tick;
        check("cancel_ack",  32'(swap_ack), 32'h0);
        check("cancel_bank", 32'(display_bank), 32'h1);
        check("cancel_addr", 32'(ram_addr), 32'h43F);
        pixel_load_en = 1'b0; tick;

        // Request rising with a boundary strobe waits for the next boundary
        swap_req = 1'b1;
        strobe(4'd0, 6'd63, 6'd1); tick;
        check("same_ack",  32'(swap_ack), 32'h0);
        check("same_bank", 32'(display_bank), 32'h1);
        pixel_load_en = 1'b0; tick;
        strobe(4'd0, 6'd63, 6'd1); tick;
        check("next_ack",  32'(swap_ack), 32'h1);
        check("next_bank", 32'(display_bank), 32'h0);
        check("next_addr", 32'(ram_addr), 32'h03F);
        pixel_load_en = 1'b0; swap_req = 1'b0; tick;

        // Move to bank 1, then reset mid-row
        swap_req = 1'b1; tick;
        strobe(4'd0, 6'd63, 6'd1); tick;
        check("pre_rst_bank", 32'(display_bank), 32'h1);
        swap_req = 1'b0; pixel_load_en = 1'b0; tick; tick; tick;
        pat_top = {12'b0, 6'b111111};
        pat_bot = '0;
        for (int i = 0; i < 10; i++) begin
            strobe(4'd7, 6'(i), 6'd8);
            tick;
        end
        reset = 1'b0;
        #1;
        check("mid_rst_vld",  32'(pixel_valid), 32'h0);
        check("mid_rst_bank", 32'(display_bank), 32'h0);
        check("mid_rst_rden", 32'(ram_rd_en), 32'h0);
        check("mid_rst_addr", 32'(ram_addr), 32'h0);
        pixel_load_en = 1'b0;
        tick; tick;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("post_rst_vld", 32'(pixel_valid), 32'h0);
        end
        strobe(4'd7, 6'd10, 6'd8); tick;
        pixel_load_en = 1'b0;
        check("s11_addr", 32'(ram_addr), 32'h1CA);
        tick;
        check("s11_vld_n1", 32'(pixel_valid), 32'h0);
        tick;
        check("s11_vld", 32'(pixel_valid), 32'h1);
        check("s11_top", 32'(rgb_top), 32'h1);
        check("s11_bot", 32'(rgb_bottom), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
